// File: rtl/mem_port_arbiter.sv
// Registered two-master arbiter: i_cache / d_cache memory ports onto a single
// outstanding axi_interface cache port, data priority bounded by a streak counter.
module mem_port_arbiter #(
  parameter bit          D_PRIORITY = 1'b1,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_m_a,
  input  logic        i_m_strobe,
  output logic        i_m_ready,
  output logic [31:0] i_m_dout,
  input  logic [31:0] d_m_a,
  input  logic        d_m_strobe,
  input  logic        d_m_rw,
  input  logic [1:0]  d_m_size,
  input  logic [3:0]  d_m_wen,
  input  logic [31:0] d_m_din,
  output logic        d_m_ready,
  output logic [31:0] d_m_dout,
  output logic [31:0] mem_a,
  output logic        mem_access,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_st_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

  localparam logic [3:0] MAX_STREAK_W = 4'(MAX_STREAK);

  state_t      state_reg, state_next;
  logic [3:0]  streak_reg, streak_next;
  logic        grant_i, grant_d;

  logic [31:0] mem_a_reg;
  logic        mem_access_reg;
  logic        mem_write_reg;
  logic [1:0]  mem_size_reg;
  logic [3:0]  mem_sel_reg;
  logic [31:0] mem_st_data_reg;
  logic        i_ready_reg, d_ready_reg;
  logic [31:0] i_dout_reg, d_dout_reg;

  // Arbitration only happens in IDLE; a streak at the limit hands one tie to
  // the non-priority side, so the counter never needs to exceed MAX_STREAK.
  always_comb begin
    state_next  = state_reg;
    streak_next = streak_reg;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_m_strobe && d_m_strobe) begin
          if (streak_reg == MAX_STREAK_W) begin
            grant_d     = !D_PRIORITY;
            grant_i     = D_PRIORITY;
            streak_next = 4'd0;
          end else begin
            grant_d     = D_PRIORITY;
            grant_i     = !D_PRIORITY;
            streak_next = streak_reg + 4'd1;
          end
        end else if (d_m_strobe) begin
          grant_d     = 1'b1;
          streak_next = 4'd0;
        end else if (i_m_strobe) begin
          grant_i     = 1'b1;
          streak_next = 4'd0;
        end
        if (grant_d) begin
          state_next = D_BUSY;
        end else if (grant_i) begin
          state_next = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_ready) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      streak_reg      <= 4'd0;
      mem_a_reg       <= 32'd0;
      mem_access_reg  <= 1'b0;
      mem_write_reg   <= 1'b0;
      mem_size_reg    <= 2'b00;
      mem_sel_reg     <= 4'b0000;
      mem_st_data_reg <= 32'd0;
      i_ready_reg     <= 1'b0;
      d_ready_reg     <= 1'b0;
      i_dout_reg      <= 32'd0;
      d_dout_reg      <= 32'd0;
    end else begin
      state_reg   <= state_next;
      streak_reg  <= streak_next;
      // Ready pulses are only ever raised from a BUSY state, so they last one cycle.
      i_ready_reg <= (state_reg == I_BUSY) && mem_ready;
      d_ready_reg <= (state_reg == D_BUSY) && mem_ready;

      if (grant_d) begin
        mem_a_reg       <= d_m_a;
        mem_access_reg  <= 1'b1;
        mem_write_reg   <= d_m_rw;
        mem_size_reg    <= d_m_size;
        mem_sel_reg     <= d_m_wen;
        mem_st_data_reg <= d_m_din;
      end else if (grant_i) begin
        mem_a_reg       <= i_m_a;
        mem_access_reg  <= 1'b1;
        mem_write_reg   <= 1'b0;
        mem_size_reg    <= 2'b10;
        mem_sel_reg     <= 4'b1111;
        mem_st_data_reg <= 32'd0;
      end

      if (mem_ready && (state_reg == I_BUSY)) begin
        mem_access_reg <= 1'b0;
        i_dout_reg     <= mem_data;
      end
      if (mem_ready && (state_reg == D_BUSY)) begin
        mem_access_reg <= 1'b0;
        d_dout_reg     <= mem_data;
      end
    end
  end

  assign mem_a       = mem_a_reg;
  assign mem_access  = mem_access_reg;
  assign mem_write   = mem_write_reg;
  assign mem_size    = mem_size_reg;
  assign mem_sel     = mem_sel_reg;
  assign mem_st_data = mem_st_data_reg;
  assign i_m_ready   = i_ready_reg;
  assign d_m_ready   = d_ready_reg;
  assign i_m_dout    = i_dout_reg;
  assign d_m_dout    = d_dout_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small axi_interface
// responder whose wait states are set per test.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic [31:0] i_m_a, d_m_a, d_m_din, mem_data;
  logic        i_m_strobe, d_m_strobe, d_m_rw, mem_ready;
  logic [1:0]  d_m_size;
  logic [3:0]  d_m_wen;
  logic        i_m_ready, d_m_ready, mem_access, mem_write;
  logic [31:0] i_m_dout, d_m_dout, mem_a, mem_st_data;
  logic [1:0]  mem_size;
  logic [3:0]  mem_sel;

  int n_checks = 0;
  int n_errors = 0;

  int          axi_wait = 0;
  int          wait_cnt = 0;
  logic [31:0] resp_data = 32'd0;
  int          spur_req = 0;
  int          spur_done = 0;
  int          i_pulses = 0;
  int          d_pulses = 0;
  int          grants = 0;
  logic        acc_prev = 1'b0;
  int          cyc = 0;

  mem_port_arbiter #(.D_PRIORITY(1'b1), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_m_a(i_m_a), .i_m_strobe(i_m_strobe), .i_m_ready(i_m_ready), .i_m_dout(i_m_dout),
    .d_m_a(d_m_a), .d_m_strobe(d_m_strobe), .d_m_rw(d_m_rw), .d_m_size(d_m_size),
    .d_m_wen(d_m_wen), .d_m_din(d_m_din), .d_m_ready(d_m_ready), .d_m_dout(d_m_dout),
    .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write), .mem_size(mem_size),
    .mem_sel(mem_sel), .mem_st_data(mem_st_data), .mem_ready(mem_ready), .mem_data(mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // axi_interface responder: one-cycle mem_ready after axi_wait busy cycles.
  always @(negedge clk) begin
    if (rst) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end else if (spur_req != spur_done) begin
      spur_done = spur_req;
      mem_ready = 1'b1;
      mem_data  = 32'hDEADDEAD;
    end else if (mem_access) begin
      if (wait_cnt >= axi_wait) begin
        mem_ready = 1'b1;
        mem_data  = resp_data;
      end else begin
        wait_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (i_m_ready) i_pulses++;
    if (d_m_ready) d_pulses++;
    if (mem_access && !acc_prev) grants++;
    acc_prev = mem_access;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input bit want_d, output bit found, output logic [31:0] dout);
    found = 1'b0;
    dout  = 32'd0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (want_d ? d_m_ready : i_m_ready) begin
        found = 1'b1;
        dout  = want_d ? d_m_dout : i_m_dout;
        $display("txn %s done after %0d cycles dout=%h", want_d ? "D" : "I", n + 1, dout);
        break;
      end
    end
    if (!found) $display("txn %s timed out", want_d ? "D" : "I");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_access"}, {31'd0, mem_access}, 32'd0);
    check({tag, "_a"}, mem_a, 32'd0);
    check({tag, "_ctl"}, {25'd0, mem_write, mem_size, mem_sel}, 32'd0);
    check({tag, "_st"}, mem_st_data, 32'd0);
    check({tag, "_rdy"}, {30'd0, i_m_ready, d_m_ready}, 32'd0);
    check({tag, "_idout"}, i_m_dout, 32'd0);
    check({tag, "_ddout"}, d_m_dout, 32'd0);
  endtask

  logic [31:0] exp_order [10];
  logic [31:0] got_order [10];
  int          t_rdy [4];

  initial begin
    bit          found;
    logic [31:0] dout;
    int          i0, d0, g0, k;

    rst = 1'b1;
    i_m_a = 32'd0; i_m_strobe = 1'b0;
    d_m_a = 32'd0; d_m_strobe = 1'b0; d_m_rw = 1'b0;
    d_m_size = 2'b00; d_m_wen = 4'b0000; d_m_din = 32'd0;
    mem_ready = 1'b0; mem_data = 32'd0;

    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single fetch
    i_m_a = 32'hBFC00000; i_m_strobe = 1'b1; axi_wait = 5; resp_data = 32'h3C080001;
    i0 = i_pulses; d0 = d_pulses;
    @(posedge clk); #1;
    check("fetch_access", {31'd0, mem_access}, 32'd1);
    check("fetch_a", mem_a, 32'hBFC00000);
    check("fetch_ctl", {25'd0, mem_write, mem_size, mem_sel}, {25'd0, 1'b0, 2'b10, 4'b1111});
    wait_ready(1'b0, found, dout);
    check("fetch_seen", {31'd0, found}, 32'd1);
    check("fetch_dout", dout, 32'h3C080001);
    i_m_strobe = 1'b0;
    @(negedge clk);
    check("fetch_pulse_one", {31'd0, i_m_ready}, 32'd0);
    check("fetch_ipulses", i_pulses - i0, 1);
    check("fetch_no_d", d_pulses - d0, 0);

    // Data store, address changes during BUSY are ignored
    d_m_a = 32'h80001004; d_m_rw = 1'b1; d_m_wen = 4'b0011; d_m_size = 2'b01;
    d_m_din = 32'h0000BEEF; d_m_strobe = 1'b1; axi_wait = 3; resp_data = 32'h0BADF00D;
    i0 = i_pulses; d0 = d_pulses;
    @(posedge clk); #1;
    check("store_access", {31'd0, mem_access}, 32'd1);
    check("store_a", mem_a, 32'h80001004);
    check("store_ctl", {25'd0, mem_write, mem_size, mem_sel}, {25'd0, 1'b1, 2'b01, 4'b0011});
    check("store_st", mem_st_data, 32'h0000BEEF);
    @(negedge clk);
    d_m_a = 32'h12345678; d_m_din = 32'hFFFFFFFF; d_m_wen = 4'b1111;
    @(posedge clk); #1;
    check("store_hold_a", mem_a, 32'h80001004);
    check("store_hold_st", mem_st_data, 32'h0000BEEF);
    check("store_hold_sel", {28'd0, mem_sel}, 32'h3);
    wait_ready(1'b1, found, dout);
    check("store_seen", {31'd0, found}, 32'd1);
    check("store_dout", dout, 32'h0BADF00D);
    d_m_strobe = 1'b0;
    @(negedge clk);
    check("store_dpulses", d_pulses - d0, 1);
    check("store_no_i", i_pulses - i0, 0);

    // Spurious mem_ready while IDLE
    i0 = i_pulses; d0 = d_pulses;
    spur_req++;
    repeat (3) @(negedge clk);
    check("spur_pulses", (i_pulses - i0) + (d_pulses - d0), 0);
    check("spur_access", {31'd0, mem_access}, 32'd0);
    check("spur_idout", i_m_dout, 32'h3C080001);
    check("spur_ddout", d_m_dout, 32'h0BADF00D);
    i_m_a = 32'h00000040; i_m_strobe = 1'b1; axi_wait = 0; resp_data = 32'h11112222;
    @(posedge clk); #1;
    check("spur_then_grant", {31'd0, mem_access}, 32'd1);
    wait_ready(1'b0, found, dout);
    check("spur_fetch_dout", dout, 32'h11112222);
    i_m_strobe = 1'b0;
    repeat (2) @(negedge clk);

    // Tie arbitration: D x4, then I once
    for (int j = 0; j < 10; j++) exp_order[j] = ((j % 5) == 4) ? 32'h00001000 : 32'h00002000;
    i_m_a = 32'h00001000; d_m_a = 32'h00002000; d_m_rw = 1'b0; d_m_wen = 4'b1111;
    d_m_size = 2'b10; axi_wait = 0; resp_data = 32'h55AA55AA;
    i_m_strobe = 1'b1; d_m_strobe = 1'b1;
    k = 0;
    for (int n = 0; n < 200 && k < 10; n++) begin
      @(negedge clk);
      if (mem_access) begin
        got_order[k] = mem_a;
        $display("txn tie grant %0d a=%h", k, mem_a);
        k++;
      end
    end
    i_m_strobe = 1'b0; d_m_strobe = 1'b0;
    check("tie_count", k, 10);
    for (int j = 0; j < 10; j++) check($sformatf("tie_order%0d", j), got_order[j], exp_order[j]);
    repeat (4) @(negedge clk);

    // Back-to-back fetches with zero-wait responder
    i_m_a = 32'h00000100; i_m_strobe = 1'b1; axi_wait = 0; resp_data = 32'h77778888;
    g0 = grants; k = 0;
    for (int n = 0; n < 60 && k < 4; n++) begin
      @(negedge clk);
      if (i_m_ready) begin
        t_rdy[k] = cyc;
        check("b2b_access_low", {31'd0, mem_access}, 32'd0);
        k++;
      end
    end
    i_m_strobe = 1'b0;
    check("b2b_count", k, 4);
    check("b2b_gap1", t_rdy[1] - t_rdy[0], 3);
    check("b2b_gap2", t_rdy[2] - t_rdy[1], 3);
    check("b2b_gap3", t_rdy[3] - t_rdy[2], 3);
    check("b2b_grants", grants - g0, 4);
    repeat (3) @(negedge clk);

    // Async reset during D_BUSY
    d_m_a = 32'h80002000; d_m_rw = 1'b0; d_m_strobe = 1'b1; axi_wait = 20;
    resp_data = 32'h99990000;
    @(posedge clk); #1;
    check("rst_busy_access", {31'd0, mem_access}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    d_m_strobe = 1'b0;
    i_m_a = 32'hBFC00010; i_m_strobe = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    axi_wait = 0;
    @(posedge clk); #1;
    check("rst_regrant_access", {31'd0, mem_access}, 32'd1);
    check("rst_regrant_a", mem_a, 32'hBFC00010);
    wait_ready(1'b0, found, dout);
    check("rst_fetch_dout", dout, 32'h99990000);
    i_m_strobe = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Registered two-master arbiter between the i_cache and d_cache memory-side ports and the single-outstanding axi_interface cache port.
- Replaces the combinational cache_miss-based mux in the CPU top.
- Latches one request at a time, holds it stable to the AXI bridge until mem_ready, then returns the read data and a one-cycle ready pulse to the winning cache.
- Arbitration gives data-side priority on ties, bounded by an anti-starvation counter.

Parameters:
- D_PRIORITY, 1, tie-break when both strobes are high in IDLE: 1 = data side wins, 0 = instruction side wins.
- MAX_STREAK, 4, maximum consecutive tie-wins for the priority side while the other side is pending; then the other side is granted once. Range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_m_a  in  32  instruction fetch address
- i_m_strobe  in  1  instruction fetch request, level, held until i_m_ready
- i_m_ready  out  1  one-cycle completion pulse to i_cache
- i_m_dout  out  32  fetched word, valid when i_m_ready=1
- d_m_a  in  32  data access address
- d_m_strobe  in  1  data request, level, held until d_m_ready
- d_m_rw  in  1  0 = read, 1 = write
- d_m_size  in  2  access size, 00 = byte, 01 = half, 10 = word
- d_m_wen  in  4  byte strobes for writes
- d_m_din  in  32  store data
- d_m_ready  out  1  one-cycle completion pulse to d_cache
- d_m_dout  out  32  load word, valid when d_m_ready=1
- mem_a  out  32  address to axi_interface
- mem_access  out  1  request valid to axi_interface
- mem_write  out  1  write flag
- mem_size  out  2  transfer size
- mem_sel  out  4  byte select
- mem_st_data  out  32  store data
- mem_ready  in  1  axi_interface completion, one cycle
- mem_data  in  32  read data, valid with mem_ready

Behaviour:
- Reset value of every output is 0. Reset also forces state IDLE, streak counter 0, and clears the latched request.
- States:
  - IDLE: neither master granted.
  - I_BUSY: instruction transaction outstanding.
  - D_BUSY: data transaction outstanding.
  - DONE: one cycle in which the ready pulse is driven.
- IDLE decision:
  - Neither strobe high: stay in IDLE.
  - One strobe high: grant that side.
  - Both high: grant the priority side unless streak == MAX_STREAK, in which case grant the other side.
- Streak counter:
  - Increments on a tie won by the priority side.
  - Clears when the non-priority side is granted, or when a grant is made without a tie.
  - Saturates at MAX_STREAK.
- On grant (edge leaving IDLE):
  - mem_a, mem_write, mem_size, mem_sel and mem_st_data are registered from the winner and mem_access is set to 1.
  - Instruction grant forces mem_write=0, mem_size=10, mem_sel=1111, mem_st_data=0.
  - Data grant copies d_m_rw, d_m_size, d_m_wen and d_m_din.
- BUSY:
  - All mem_* outputs hold constant. Upstream input changes are ignored.
  - On mem_ready=1: mem_access goes to 0, mem_data is captured into the winner's dout register, and the state moves to DONE.
- DONE:
  - Winner's ready = 1 for exactly this cycle; the other ready stays 0.
  - Both strobes are ignored; arbitration resumes in the following IDLE cycle.
  - i_m_dout / d_m_dout hold their last captured value until the next capture for that side.
- Latency: strobe sampled at edge N; mem_access=1 during cycle N+1; mem_ready in cycle M gives ready=1 in cycle M+1. Minimum strobe-to-ready is 3 cycles, and the bus is idle for 2 cycles between back-to-back grants.
- mem_ready while in IDLE or DONE is ignored and has no effect on state or data.
- A strobe that drops before it is granted is treated as withdrawn. A strobe dropping during BUSY does not cancel the transaction.
- Reset mid-transaction aborts it: no ready pulse, outputs go to 0. The axi_interface is reset by the same rst.

Test Plan:
- Single fetch: i_m_strobe=1, i_m_a=0xBFC00000, mem_ready after 5 cycles with mem_data=0x3C080001 -> mem_access high with mem_a=0xBFC00000, mem_sel=1111, mem_size=10, mem_write=0; i_m_ready pulses one cycle with i_m_dout=0x3C080001; d_m_ready stays 0.
- Data store: d_m_strobe=1, d_m_rw=1, d_m_a=0x80001004, d_m_wen=0011, d_m_size=01, d_m_din=0x0000BEEF -> mem_* reflect these exactly and stay stable even if d_m_a changes during BUSY; d_m_ready pulses once.
- Tie with D_PRIORITY=1, MAX_STREAK=4: both strobes held, each completed side re-requests immediately -> grant order D,D,D,D,I,D,D,D,D,I.
- Spurious mem_ready pulse while IDLE -> no state change, no ready pulse, dout unchanged.
- Async reset asserted during D_BUSY -> all outputs 0 immediately with no clock edge needed; after release, a pending i_m_strobe is granted within 1 cycle.
- Back-to-back fetches, axi_interface with zero-wait mem_ready -> ready pulses spaced exactly 3 cycles apart; no double grant of the same request during DONE.
